key_event_scanner: RTL and testbench

Sequencer that sits downstream of the key debouncer. It walks the debounced key vector one key per clock and compares each key against a shadow copy of the last reported state. Each change becomes a key event {index, new level}, held in a small FIFO and presented on a valid/ready port to the host-interface side (the SPI link). Events are never dropped: while the FIFO is full, the scan stalls.

---
 rtl/keys_pkg.sv | 19 +
 rtl/key_evt_fifo.sv | 54 +++++
 rtl/key_event_scanner.sv | 115 +++++++++++
 tb/tb_key_event_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/keys_pkg.sv
// Shared types for the key event scanner.
// Event record layout and scan FSM states.
package keys_pkg;

    localparam int KEYS_DEF  = 89;
    localparam int KEY_IDX_W = $clog2(KEYS_DEF);

    typedef struct packed {
        logic [KEY_IDX_W-1:0] idx;
        logic                 state;
    } key_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_STALL = 2'd2
    } scan_state_t;

endpackage

// File: rtl/key_evt_fifo.sv
// First-word fall-through event FIFO.
// Full/empty come from the registered count only.
module key_evt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_valid = (r_cnt != '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && o_valid;
    assign o_data  = o_valid ? r_mem[r_rd] : '0;

    // Pointers and occupancy; a refused push leaves the count alone
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage array; contents are masked by o_valid so need no reset
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/key_event_scanner.sv
// Walks the debounced key vector one key per clock and queues
// {index, level} events for every change against a shadow copy.
module key_event_scanner
    import keys_pkg::*;
#(
    parameter int KEYS       = KEYS_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int IDX_W      = $clog2(KEYS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [KEYS-1:0]  keys_i,
    input  logic             scan_en_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [IDX_W-1:0] evt_key_o,
    output logic             evt_state_o,
    output logic             busy_o,
    output logic             scan_done_o
);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [KEYS-1:0]  r_shadow;
    logic             w_key;
    logic             w_diff;
    logic             w_last;
    logic             w_full;
    logic             w_push;
    logic             w_done;
    logic [IDX_W:0]   w_head;

    assign w_key  = keys_i[r_ptr];
    assign w_diff = w_key ^ r_shadow[r_ptr];
    assign w_last = (r_ptr == IDX_W'(KEYS-1));

    // Next state, pointer advance, event push and pass-done strobe
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_push      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (scan_en_i) begin
                    w_state_nxt = ST_SCAN;
                    w_ptr_nxt   = '0;
                end
            end
            ST_SCAN: begin
                if (w_diff && w_full) begin
                    w_state_nxt = ST_STALL;
                end else begin
                    w_push = w_diff;
                    if (w_last) begin
                        w_done      = 1'b1;
                        w_ptr_nxt   = '0;
                        w_state_nxt = scan_en_i ? ST_SCAN : ST_IDLE;
                    end else begin
                        w_ptr_nxt = r_ptr + IDX_W'(1);
                    end
                end
            end
            ST_STALL: begin
                if (!w_full) w_state_nxt = ST_SCAN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // FSM state and scan pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Shadow follows only the levels that were actually reported
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shadow <= '1;
        end else if (w_push) begin
            r_shadow[r_ptr] <= w_key;
        end
    end

    key_evt_fifo #(
        .W     (IDX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_data  ({r_ptr, w_key}),
        .o_full  (w_full),
        .i_pop   (evt_ready_i),
        .o_valid (evt_valid_o),
        .o_data  (w_head)
    );

    assign evt_key_o   = w_head[IDX_W:1];
    assign evt_state_o = w_head[0];
    assign busy_o      = (r_state != ST_IDLE);
    assign scan_done_o = w_done;

endmodule

// File: tb/tb_key_event_scanner.sv
// Randomised scoreboard bench for key_event_scanner.
// Reference model applies the scan rules with plain arrays/queues.
module tb_key_event_scanner;
    import keys_pkg::*;

    localparam int KEYS  = 89;
    localparam int DEPTH = 8;
    localparam int IW    = $clog2(KEYS);

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            ready;
    logic [KEYS-1:0] keys;
    logic            evt_valid;
    logic [IW-1:0]   evt_key;
    logic            evt_state;
    logic            busy;
    logic            scan_done;

    key_event_scanner #(
        .KEYS       (KEYS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .keys_i      (keys),
        .scan_en_i   (en),
        .evt_valid_o (evt_valid),
        .evt_ready_i (ready),
        .evt_key_o   (evt_key),
        .evt_state_o (evt_state),
        .busy_o      (busy),
        .scan_done_o (scan_done)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_SCAN, M_STALL} mode_t;

    int            n_pass = 0;
    int            n_total = 0;
    key_evt_t      exp_q[$];
    mode_t         m_mode = M_IDLE;
    int            m_ptr = 0;
    bit [KEYS-1:0] m_sh = '1;
    int            m_cnt = 0;
    bit            m_after_rst = 1'b0;
    int            k60_evts = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
    endtask

    // Reference model: checks present outputs, then advances one clock
    always @(negedge clk) begin
        bit    pop;
        bit    full;
        bit    done;
        bit    chg;
        mode_t prev;
        prev = m_mode;
        pop  = (m_cnt > 0) && ready;
        full = (m_cnt >= DEPTH);
        done = 1'b0;
        chk("busy", int'(busy), int'(prev != M_IDLE));
        chk("valid", int'(evt_valid), int'(m_cnt > 0));
        if (m_after_rst) begin
            chk("rst_evt_data", int'({evt_key, evt_state}), 0);
            chk("rst_done", int'(scan_done), 0);
            m_after_rst = 1'b0;
        end
        case (m_mode)
            M_IDLE: begin
                if (en) begin
                    m_mode = M_SCAN;
                    m_ptr  = 0;
                end
            end
            M_SCAN: begin
                chg = keys[m_ptr] != m_sh[m_ptr];
                if (chg && full) begin
                    m_mode = M_STALL;
                end else begin
                    if (chg) begin
                        exp_q.push_back(key_evt_t'{idx: IW'(m_ptr), state: keys[m_ptr]});
                        m_sh[m_ptr] = keys[m_ptr];
                        m_cnt++;
                    end
                    if (m_ptr == KEYS - 1) begin
                        done   = 1'b1;
                        m_ptr  = 0;
                        m_mode = en ? M_SCAN : M_IDLE;
                    end else begin
                        m_ptr++;
                    end
                end
            end
            default: begin
                if (!full) m_mode = M_SCAN;
            end
        endcase
        chk("scan_done", int'(scan_done), int'(done));
        if (pop) m_cnt--;
        if (rst) begin
            m_mode = M_IDLE;
            m_ptr  = 0;
            m_sh   = '1;
            m_cnt  = 0;
            exp_q.delete();
            m_after_rst = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted event
    always @(negedge clk) begin
        key_evt_t e;
        if (!rst && evt_valid && ready) begin
            if (evt_key == IW'(60)) k60_evts++;
            if (exp_q.size() == 0) begin
                chk("unexpected_evt", int'({evt_key, evt_state}), -1);
            end else begin
                e = exp_q.pop_front();
                chk("event", int'({evt_key, evt_state}), int'(e));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int k60_before;
        int waited;
        rst   = 1'b1;
        en    = 1'b0;
        ready = 1'b1;
        keys  = '1;
        cyc(3);
        rst = 1'b0;
        cyc(2);
        en = 1'b1;
        cyc(200);
        keys[5] = 1'b0;
        cyc(100);
        keys[5] = 1'b1;
        cyc(100);
        keys[3]  = 1'b0;
        keys[40] = 1'b0;
        keys[88] = 1'b0;
        cyc(100);
        keys = '1;
        cyc(100);
        ready = 1'b0;
        for (int i = 0; i < 10; i++) keys[i*8+1] = 1'b0;
        cyc(150);
        ready = 1'b1;
        cyc(150);
        keys = '1;
        cyc(150);
        ready = 1'b0;
        for (int i = 0; i < 10; i++) keys[i*8+2] = 1'b0;
        cyc(150);
        rst = 1'b1;
        cyc(1);
        rst   = 1'b0;
        keys  = '1;
        ready = 1'b1;
        cyc(100);
        k60_before = k60_evts;
        waited = 0;
        while (!(m_mode == M_SCAN && m_ptr == 5) && waited < 500) begin
            cyc(1);
            waited++;
        end
        chk("wait_ptr5", int'(waited < 500), 1);
        keys[60] = 1'b0;
        cyc(3);
        keys[60] = 1'b1;
        cyc(200);
        chk("no_evt_k60", k60_evts, k60_before);
        for (int c = 0; c < 3000; c++) begin
            ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) keys[$urandom_range(0, KEYS-1)] ^= 1'b1;
            if ($urandom_range(0, 299) == 0) en = ~en;
            rst = ($urandom_range(0, 1499) == 0);
            cyc(1);
        end
        rst   = 1'b0;
        en    = 1'b1;
        ready = 1'b1;
        cyc(400);
        chk("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
